// File: rtl/opb_swreg_bank_sequencer.sv
// OPB sequencer for a bank of software-register slaves sharing one address window:
// decodes the window to a one-hot select, forwards the selected response one cycle later
// and terminates hung accesses with a watchdog error acknowledge.
module opb_swreg_bank_sequencer #(
    parameter int          N_SLAVES       = 4,
    parameter logic [31:0] C_BASEADDR     = 32'h0100E000,
    parameter int          SPAN_LOG2      = 8,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic                    OPB_select,
    input  logic [0:31]             OPB_ABus,
    input  logic                    OPB_RNW,
    output logic [N_SLAVES-1:0]     Sl_sel,
    input  logic [32*N_SLAVES-1:0]  SlIn_DBus,
    input  logic [N_SLAVES-1:0]     SlIn_xferAck,
    input  logic [N_SLAVES-1:0]     SlIn_errAck,
    input  logic [N_SLAVES-1:0]     SlIn_retry,
    input  logic [N_SLAVES-1:0]     SlIn_toutSup,
    output logic [0:31]             Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    busy,
    output logic [15:0]             tout_count
);

    localparam int              IDX_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0]     WINDOW  = 32'(N_SLAVES) << SPAN_LOG2;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             rnw_q;
    logic [WD_W-1:0]  wd_q;
    logic             xfer_q, err_q, retry_q, tsup_q;
    logic [31:0]      dbus_q;
    logic [15:0]      tout_q;

    logic [31:0] offset;
    logic        hit;
    logic        sel_err, sel_xfer, sel_retry, sel_tsup;
    logic [31:0] sel_data;
    logic        in_wait, wd_expire;
    logic        resp_err, resp_xfer, resp_retry, resp_tout;

    // Offset is only meaningful when the address is at or above the base.
    assign offset = OPB_ABus - C_BASEADDR;
    assign hit    = OPB_select && (OPB_ABus >= C_BASEADDR) && (offset < WINDOW);

    // Only the latched slave is observed; every other slave's lines are ignored.
    assign sel_err   = SlIn_errAck[idx_q];
    assign sel_xfer  = SlIn_xferAck[idx_q];
    assign sel_retry = SlIn_retry[idx_q];
    assign sel_tsup  = SlIn_toutSup[idx_q];
    assign sel_data  = SlIn_DBus[32*idx_q +: 32];

    assign in_wait   = (state_q == ST_WAIT) && OPB_select;
    assign wd_expire = !sel_tsup && (wd_q == WD_LAST);

    assign resp_err   = in_wait && sel_err;
    assign resp_xfer  = in_wait && !sel_err && sel_xfer;
    assign resp_retry = in_wait && !sel_err && !sel_xfer && sel_retry;
    assign resp_tout  = in_wait && !sel_err && !sel_xfer && !sel_retry && wd_expire;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hit) state_d = ST_WAIT;
            ST_WAIT: begin
                if (!OPB_select) begin
                    state_d = ST_IDLE;
                end else if (sel_err || sel_xfer || sel_retry || wd_expire) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Sl_sel = '0;
        busy   = (state_q != ST_IDLE);
        if (state_q == ST_WAIT) begin
            Sl_sel[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            idx_q   <= '0;
            rnw_q   <= 1'b0;
            wd_q    <= '0;
            xfer_q  <= 1'b0;
            err_q   <= 1'b0;
            retry_q <= 1'b0;
            tsup_q  <= 1'b0;
            dbus_q  <= '0;
            tout_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && hit) begin
                idx_q <= offset[SPAN_LOG2 +: IDX_W];
                rnw_q <= OPB_RNW;
            end

            if (state_q != ST_WAIT) begin
                wd_q <= '0;
            end else if (!sel_tsup) begin
                wd_q <= wd_q + 1'b1;
            end

            // Response registers are loaded only on the WAIT->RESP edge, giving 1-cycle pulses.
            xfer_q  <= resp_xfer;
            err_q   <= resp_err || resp_tout;
            retry_q <= resp_retry;
            tsup_q  <= in_wait && sel_tsup;
            dbus_q  <= (resp_xfer && rnw_q) ? sel_data : 32'h0;

            if (resp_tout && tout_q != 16'hFFFF) begin
                tout_q <= tout_q + 16'd1;
            end
        end
    end

    assign Sl_DBus    = dbus_q;
    assign Sl_xferAck = xfer_q;
    assign Sl_errAck  = err_q;
    assign Sl_retry   = retry_q;
    assign Sl_toutSup = tsup_q;
    assign tout_count = tout_q;

endmodule

// File: tb/tb_opb_swreg_bank_sequencer.sv
// Directed bench: stimulus pushes expected bus responses (kind, data, cycle) into a queue;
// a negedge monitor pops and compares each response the sequencer presents.
module tb_opb_swreg_bank_sequencer;

    localparam int N = 4;

    localparam logic [2:0] K_ERR   = 3'b100;
    localparam logic [2:0] K_XFER  = 3'b010;
    localparam logic [2:0] K_RETRY = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic            OPB_Clk = 1'b0;
    logic            OPB_Rst = 1'b1;
    logic            OPB_select = 1'b0;
    logic [0:31]     OPB_ABus = '0;
    logic            OPB_RNW = 1'b0;
    logic [N-1:0]    Sl_sel;
    logic [32*N-1:0] SlIn_DBus = '0;
    logic [N-1:0]    SlIn_xferAck = '0;
    logic [N-1:0]    SlIn_errAck = '0;
    logic [N-1:0]    SlIn_retry = '0;
    logic [N-1:0]    SlIn_toutSup = '0;
    logic [0:31]     Sl_DBus;
    logic            Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, busy;
    logic [15:0]     tout_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    opb_swreg_bank_sequencer #(
        .N_SLAVES(N), .C_BASEADDR(32'h0100E000), .SPAN_LOG2(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_select(OPB_select),
        .OPB_ABus(OPB_ABus), .OPB_RNW(OPB_RNW), .Sl_sel(Sl_sel),
        .SlIn_DBus(SlIn_DBus), .SlIn_xferAck(SlIn_xferAck), .SlIn_errAck(SlIn_errAck),
        .SlIn_retry(SlIn_retry), .SlIn_toutSup(SlIn_toutSup), .Sl_DBus(Sl_DBus),
        .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
        .Sl_toutSup(Sl_toutSup), .busy(busy), .tout_count(tout_count)
    );

    always #5 OPB_Clk = ~OPB_Clk;
    always @(posedge OPB_Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pulse must match the head of the queue; otherwise data is 0.
    always @(negedge OPB_Clk) begin
        if (Sl_xferAck || Sl_errAck || Sl_retry) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got err/xfer/retry=%b%b%b, expected none (cycle %0d)",
                         Sl_errAck, Sl_xferAck, Sl_retry, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_kind", {29'b0, Sl_errAck, Sl_xferAck, Sl_retry}, {29'b0, e.kind});
                check("resp_data", Sl_DBus, e.data);
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            check("idle_dbus", Sl_DBus, 32'h0);
        end
    end

    task automatic tick();
        @(posedge OPB_Clk);
        #1;
    endtask

    task automatic expect_resp(input logic [2:0] kind, input logic [31:0] data, input int at);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic quiet_bus();
        OPB_select   = 1'b0;
        SlIn_DBus    = '0;
        SlIn_xferAck = '0;
        SlIn_errAck  = '0;
        SlIn_retry   = '0;
        SlIn_toutSup = '0;
    endtask

    task automatic start(input logic [31:0] addr, input logic rnw);
        OPB_select = 1'b1;
        OPB_ABus   = addr;
        OPB_RNW    = rnw;
    endtask

    initial begin
        int c0;
        #1 OPB_Rst = 1'b0;
        #20;
        check("rst_sel", 32'(Sl_sel), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_tout_count", 32'(tout_count), 32'h0);
        check("rst_acks", {29'b0, Sl_errAck, Sl_xferAck, Sl_retry}, 32'h0);
        tick();
        OPB_Rst = 1'b1;
        tick();

        // Read slave 1, ack at cycle 3 -> bus ack with data at cycle 4.
        c0 = cyc;
        start(32'h0100E104, 1'b1);
        tick();
        check("rd_sel_c1", 32'(Sl_sel), 32'h2);
        check("rd_busy_c1", 32'(busy), 32'h1);
        tick();
        tick();
        check("rd_sel_c3", 32'(Sl_sel), 32'h2);
        SlIn_xferAck[1] = 1'b1;
        SlIn_DBus[32*1 +: 32] = 32'hDEADBEEF;
        expect_resp(K_XFER, 32'hDEADBEEF, c0 + 4);
        tick();
        check("rd_sel_resp", 32'(Sl_sel), 32'h0);
        quiet_bus();
        tick();
        check("rd_busy_after", 32'(busy), 32'h0);

        // Write slave 3 while slave 0 acks spuriously; no data forwarded on a write.
        c0 = cyc;
        start(32'h0100E300, 1'b0);
        tick();
        check("wr_sel", 32'(Sl_sel), 32'h8);
        tick();
        SlIn_xferAck[0] = 1'b1;
        SlIn_DBus[0 +: 32] = 32'h11111111;
        tick();
        SlIn_xferAck[0] = 1'b0;
        tick();
        tick();
        SlIn_xferAck[3] = 1'b1;
        SlIn_DBus[32*3 +: 32] = 32'h12345678;
        expect_resp(K_XFER, 32'h0, c0 + 6);
        tick();
        quiet_bus();
        tick();

        // Watchdog: no response on slave 2 -> errAck at cycle 17, count 0 -> 1.
        check("tout_count_pre", 32'(tout_count), 32'h0);
        c0 = cyc;
        start(32'h0100E200, 1'b1);
        expect_resp(K_ERR, 32'h0, c0 + 17);
        repeat (17) tick();
        quiet_bus();
        tick();
        check("tout_count_post", 32'(tout_count), 32'h1);
        check("tout_busy_after", 32'(busy), 32'h0);

        // Suppressed watchdog for 40 cycles: no errAck, toutSup forwarded; then abort.
        start(32'h0100E200, 1'b1);
        SlIn_toutSup[2] = 1'b1;
        tick();
        tick();
        check("tsup_fwd", 32'(Sl_toutSup), 32'h1);
        repeat (38) tick();
        check("tsup_still_busy", 32'(busy), 32'h1);
        quiet_bus();
        tick();
        check("tsup_abort_idle", 32'(busy), 32'h0);
        check("tsup_cleared", 32'(Sl_toutSup), 32'h0);
        check("tsup_count_held", 32'(tout_count), 32'h1);

        // errAck and xferAck in the same cycle -> only errAck, no data.
        c0 = cyc;
        start(32'h0100E000, 1'b1);
        tick();
        SlIn_errAck[0] = 1'b1;
        SlIn_xferAck[0] = 1'b1;
        SlIn_DBus[0 +: 32] = 32'hCAFEF00D;
        expect_resp(K_ERR, 32'h0, c0 + 2);
        tick();
        quiet_bus();
        tick();

        // xferAck beats retry; read data forwarded.
        c0 = cyc;
        start(32'h0100E2A0, 1'b1);
        tick();
        tick();
        SlIn_xferAck[2] = 1'b1;
        SlIn_retry[2] = 1'b1;
        SlIn_DBus[32*2 +: 32] = 32'h55AA55AA;
        expect_resp(K_XFER, 32'h55AA55AA, c0 + 3);
        tick();
        quiet_bus();
        tick();

        // Retry alone at the top byte of slave 1's window.
        c0 = cyc;
        start(32'h0100E1FC, 1'b1);
        tick();
        check("retry_sel", 32'(Sl_sel), 32'h2);
        SlIn_retry[1] = 1'b1;
        expect_resp(K_RETRY, 32'h0, c0 + 2);
        tick();
        quiet_bus();
        tick();

        // Master abort in WAIT: back to IDLE, no ack and no later watchdog firing.
        start(32'h0100E100, 1'b0);
        tick();
        tick();
        OPB_select = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_sel", 32'(Sl_sel), 32'h0);
        repeat (20) tick();
        check("abort_count", 32'(tout_count), 32'h1);

        // Out of window: just above the bank and just below the base.
        start(32'h0100E400, 1'b1);
        tick();
        check("oow_hi_sel", 32'(Sl_sel), 32'h0);
        check("oow_hi_busy", 32'(busy), 32'h0);
        start(32'h0100DFFC, 1'b1);
        tick();
        tick();
        check("oow_lo_sel", 32'(Sl_sel), 32'h0);
        check("oow_lo_busy", 32'(busy), 32'h0);
        repeat (20) tick();
        quiet_bus();
        tick();

        // Back-to-back: new address presented during RESP is accepted in the following IDLE.
        c0 = cyc;
        start(32'h0100E200, 1'b1);
        tick();
        SlIn_xferAck[2] = 1'b1;
        SlIn_DBus[32*2 +: 32] = 32'h01020304;
        expect_resp(K_XFER, 32'h01020304, c0 + 2);
        tick();
        SlIn_xferAck[2] = 1'b0;
        start(32'h0100E310, 1'b1);
        tick();
        check("b2b_idle_sel", 32'(Sl_sel), 32'h0);
        tick();
        check("b2b_sel", 32'(Sl_sel), 32'h8);
        SlIn_xferAck[3] = 1'b1;
        SlIn_DBus[32*3 +: 32] = 32'h0BADF00D;
        expect_resp(K_XFER, 32'h0BADF00D, c0 + 5);
        tick();
        quiet_bus();
        tick();

        // Async reset between edges while a slave ack is pending: all outputs clear at once.
        start(32'h0100E100, 1'b1);
        tick();
        tick();
        SlIn_xferAck[1] = 1'b1;
        SlIn_DBus[32*1 +: 32] = 32'hFFFFFFFF;
        #2 OPB_Rst = 1'b0;
        #1;
        check("arst_sel", 32'(Sl_sel), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_count", 32'(tout_count), 32'h0);
        tick();
        quiet_bus();
        check("arst_no_ack", {29'b0, Sl_errAck, Sl_xferAck, Sl_retry}, 32'h0);
        tick();
        OPB_Rst = 1'b1;
        repeat (3) tick();

        check("pending_responses", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/opb_swreg_bank_sequencer.md
Name: opb_swreg_bank_sequencer

Overview:
Sequences OPB transactions onto a bank of software-register slaves (simulink2ppc / ppc2simulink style) sharing one address window. It decodes the OPB address to a one-hot slave select and forwards the selected slave's response. It also enforces a bus watchdog that terminates hung accesses with an error acknowledge. It sits between the OPB bus and the register wrappers, replacing per-slave OR-ing of response lines.

Parameters:
N_SLAVES, 4, number of register slaves in the bank (1..16)
C_BASEADDR, 32'h0100E000, bank base address; aligned to N_SLAVES*2^SPAN_LOG2
SPAN_LOG2, 8, log2 of bytes per slave window (256 B, matching a 0x..00-0x..FF register slot)
TIMEOUT_CYCLES, 16, cycles in WAIT without slave response before watchdog fires (>=2)

Ports:
OPB_Clk  in  1  bus clock; all logic on rising edge
OPB_Rst  in  1  asynchronous, active-low reset
OPB_select  in  1  master select
OPB_ABus  in  [0:31]  address, bit 0 = MSB
OPB_RNW  in  1  1 = read
Sl_sel  out  N_SLAVES  one-hot select to slave i (drives that slave's OPB_select)
SlIn_DBus  in  32*N_SLAVES  slave i read data at bits [32i+31:32i]
SlIn_xferAck  in  N_SLAVES  per-slave transfer ack
SlIn_errAck  in  N_SLAVES  per-slave error ack
SlIn_retry  in  N_SLAVES  per-slave retry
SlIn_toutSup  in  N_SLAVES  per-slave timeout suppress
Sl_DBus  out  [0:31]  read data to bus
Sl_xferAck  out  1  transfer ack to bus
Sl_errAck  out  1  error ack to bus
Sl_retry  out  1  retry to bus
Sl_toutSup  out  1  timeout suppress to bus
busy  out  1  high in any state other than IDLE
tout_count  out  16  saturating count of watchdog terminations

Behaviour:
- Reset (OPB_Rst=0, async): state IDLE; Sl_sel, Sl_DBus, all Sl_* acks, busy = 0; tout_count = 0; watchdog counter = 0.
- Hit: OPB_select=1 and C_BASEADDR <= ABus < C_BASEADDR + N_SLAVES*2^SPAN_LOG2. Index idx = (ABus - C_BASEADDR) >> SPAN_LOG2, latched at the hit.
- IDLE: on hit -> WAIT; Sl_sel[idx]=1 from the next cycle; watchdog cleared. Miss: stay IDLE, drive nothing.
- WAIT: Sl_sel[idx] held. Only slave idx's inputs are observed; all others are ignored.
  - Sl_toutSup follows SlIn_toutSup[idx], registered.
  - Watchdog increments each cycle unless SlIn_toutSup[idx]=1, in which case it holds.
  - Response priority, same cycle: errAck > xferAck > retry.
    - errAck: Sl_errAck=1 next cycle -> RESP.
    - xferAck: Sl_xferAck=1 next cycle; if RNW, Sl_DBus = SlIn_DBus[idx] for that cycle -> RESP.
    - retry: Sl_retry=1 next cycle -> RESP.
  - Watchdog reaches TIMEOUT_CYCLES with no response: Sl_errAck=1 next cycle; tout_count++ (saturates at 16'hFFFF) -> RESP.
  - OPB_select drops (master abort): Sl_sel=0 next cycle -> IDLE; no ack; no count.
- RESP: exactly one cycle. The ack/retry pulse and data are valid here; Sl_sel=0. Unconditionally -> IDLE next cycle.
- Latency: slave ack at cycle n -> bus ack at n+1 (one register stage). Every Sl_* output is a 1-cycle pulse.
- Sl_DBus = 0 in every cycle except a read xferAck cycle (OR-bus rule). Writes never drive data.
- New hit in IDLE the cycle after RESP is accepted (back-to-back supported).
- Reset asserted mid-transaction: immediate return to reset values; any pending ack is discarded.

Test Plan:
- Read slave 1: ABus=0x0100E104, RNW=1; SlIn_xferAck[1] at cycle 3 with data 0xDEADBEEF -> Sl_sel=0b0010 cycles 1-3; Sl_xferAck and Sl_DBus=0xDEADBEEF at cycle 4 only; Sl_DBus=0 otherwise.
- Write slave 3 with slave 0 acking spuriously: ABus=0x0100E300, RNW=0; SlIn_xferAck[0] at cycle 2, SlIn_xferAck[3] at cycle 5 -> single Sl_xferAck at cycle 6; Sl_DBus stays 0.
- Timeout: ABus=0x0100E200, no response, TIMEOUT_CYCLES=16 -> Sl_errAck pulse at cycle 17; tout_count 0->1. Repeat with SlIn_toutSup[2] held high for 40 cycles -> no errAck; Sl_toutSup high.
- Priority/abort: errAck and xferAck same cycle -> only Sl_errAck. OPB_select dropped in WAIT -> IDLE, no ack.
- Out of window: ABus=0x0100E400 (N_SLAVES=4) and 0x0100DFFC -> Sl_sel=0, busy=0, no response.
- Async reset mid-WAIT: OPB_Rst=0 between clock edges -> Sl_sel, busy, and outputs go to 0 immediately; tout_count=0.
